ddr3_app_arbiter: RTL and testbench
===================================

# ddr3_app_arbiter

Two-client arbiter and sequencer for the DDR3 memory-controller application (app_*) interface, sitting between user-side memory clients and the DDR3 wrapper in the ui_clk domain. It grants single-beat read/write requests round-robin and drives app_en/app_cmd/app_addr together with the write-data channel. It tracks in-order read returns with a client-tag FIFO so each read beat is routed back to its requester, and blocks all traffic until calibration completes.

## Interface
- ADDR_W, 28, app_addr width
- DATA_W, 256, app data width (one beat per command)
- MASK_W, DATA_W/8, byte mask width (1 = byte NOT written, controller convention)
- MAX_RD, 16, max outstanding reads; power of two, ≥2
- ui_clk  in  1  controller user clock; all logic on rising edge
- ui_clk_sync_rst  in  1  reset; synchronous, active-high
- init_calib_complete  in  1  controller calibration done
- c0_req_valid / c1_req_valid  in  1  client request present
- c0_req_ready / c1_req_ready  out  1  request accepted this cycle when valid&ready
- c0_req_write / c1_req_write  in  1  1 = write, 0 = read
- c0_req_addr / c1_req_addr  in  ADDR_W  address
- c0_req_data / c1_req_data  in  DATA_W  write data
- c0_req_mask / c1_req_mask  in  MASK_W  write byte mask
- rsp_valid  out  1  read beat returned (no backpressure; clients must sink)
- rsp_client  out  1  requester of the returned beat
- rsp_data  out  DATA_W  read data
- app_addr  out  ADDR_W; app_cmd  out  3 (3'b000 write, 3'b001 read); app_en  out  1
- app_rdy  in  1; app_wdf_rdy  in  1
- app_wdf_data  out  DATA_W; app_wdf_mask  out  MASK_W; app_wdf_wren  out  1; app_wdf_end  out  1
- app_rd_data  in  DATA_W; app_rd_data_valid  in  1
- rd_outstanding  out  clog2(MAX_RD)+1  reads issued, data not yet returned
- err_underflow  out  1  sticky: read beat arrived with tag FIFO empty

## Operation
- States: IDLE, ISSUE. Reset → IDLE.
- IDLE: if init_calib_complete=0, both ready=0. Otherwise, eligible client = valid & (write | rd_outstanding<MAX_RD). Among eligible clients, one is granted round-robin: prefer client ≠ last_grant. last_grant resets to 1, so client 0 wins first. Granted client sees ready=1 (combinational from state, calib, valids, count); other ready=0.
- On accept: register addr/cmd/data/mask, set cmd_done=0 and data_done=(read). Read: push client id into tag FIFO and increment rd_outstanding that cycle. Update last_grant. → ISSUE.
- ISSUE: app_en=1 while !cmd_done; cmd_done set on app_en&app_rdy. app_wdf_wren=app_wdf_end=1 while !data_done; data_done set on wren&app_wdf_rdy. Command and data channels complete independently, in either order. When both are done (including the handshake cycle itself) → IDLE. No new request is accepted in ISSUE.
- Read return: on app_rd_data_valid, rsp_valid=1, rsp_data=app_rd_data, rsp_client=FIFO head (combinational); pop FIFO, decrement count. FIFO empty at that moment → rsp_client=0, err_underflow←1, count held at 0.
- Push and pop in the same cycle: count unchanged, FIFO order preserved.
- init_calib_complete falling mid-ISSUE: the transaction completes; no further grants.
- Reset mid-operation: all state discarded, FIFO emptied, err_underflow cleared.

## Timing
- Reset values: all ready=0, app_en=0, app_wdf_wren=0, app_wdf_end=0, rsp_valid=0, rd_outstanding=0, err_underflow=0, app_cmd=3'b001, app_addr/wdf_data/wdf_mask=0.
- Accept at cycle N → app_en (and wren for writes) high at N+1. With app_rdy=app_wdf_rdy=1 throughout, back-to-back requests issue every 2 cycles.
- rsp_* are combinational from app_rd_data_valid/app_rd_data; zero latency.
- app_addr, app_cmd, and app_wdf_* are stable while their enable is held.

## Test plan
- Calib low, c0 read valid → ready stays 0, app_en 0; raise calib → accept next cycle, app_en=1, cmd=001 the cycle after.
- Both clients writing continuously, rdy=1 → grants alternate 0,1,0,1; app_addr sequence matches; mask passed unaltered.
- Write with app_rdy=1 and app_wdf_rdy low for 3 cycles → app_en drops after 1 cycle, wren held 4 cycles, then IDLE.
- MAX_RD=4, c1 issues 4 reads with no return → c1 ready=0 for reads, c0 write still granted. One return → rd_outstanding 3 → read granted.
- Interleaved reads from c0,c1,c1,c0 → returns tagged 0,1,1,0 with matching data. Return in same cycle as new read push → count unchanged.
- app_rd_data_valid with nothing outstanding → err_underflow=1 and sticky until reset.

Source files
------------

// File: rtl/ddr3_app_arbiter_if.sv
// Bundle of client-side and controller-side signals for ddr3_app_arbiter.
// Ports:
//   clients    : c0/c1 req_valid/ready/write/addr/data/mask
//   responses  : rsp_valid, rsp_client, rsp_data
//   controller : init_calib_complete, app_* command, write-data and read-data
//   status     : rd_outstanding, err_underflow
// Modport master is the arbiter side; slave is the clients plus controller side.
interface ddr3_app_arbiter_if #(
   parameter int unsigned ADDR_W = 28,
   parameter int unsigned DATA_W = 256,
   parameter int unsigned MASK_W = DATA_W / 8,
   parameter int unsigned MAX_RD = 16
);
   localparam int unsigned CNT_W = $clog2(MAX_RD) + 1;

   logic              init_calib_complete;
   logic              c0_req_valid;
   logic              c0_req_ready;
   logic              c0_req_write;
   logic [ADDR_W-1:0] c0_req_addr;
   logic [DATA_W-1:0] c0_req_data;
   logic [MASK_W-1:0] c0_req_mask;
   logic              c1_req_valid;
   logic              c1_req_ready;
   logic              c1_req_write;
   logic [ADDR_W-1:0] c1_req_addr;
   logic [DATA_W-1:0] c1_req_data;
   logic [MASK_W-1:0] c1_req_mask;
   logic              rsp_valid;
   logic              rsp_client;
   logic [DATA_W-1:0] rsp_data;
   logic [ADDR_W-1:0] app_addr;
   logic [2:0]        app_cmd;
   logic              app_en;
   logic              app_rdy;
   logic              app_wdf_rdy;
   logic [DATA_W-1:0] app_wdf_data;
   logic [MASK_W-1:0] app_wdf_mask;
   logic              app_wdf_wren;
   logic              app_wdf_end;
   logic [DATA_W-1:0] app_rd_data;
   logic              app_rd_data_valid;
   logic [CNT_W-1:0]  rd_outstanding;
   logic              err_underflow;

   modport master (
      input  init_calib_complete,
      input  c0_req_valid, c0_req_write, c0_req_addr, c0_req_data, c0_req_mask,
      input  c1_req_valid, c1_req_write, c1_req_addr, c1_req_data, c1_req_mask,
      output c0_req_ready, c1_req_ready,
      output rsp_valid, rsp_client, rsp_data,
      output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
      input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
      output rd_outstanding, err_underflow
   );

   modport slave (
      output init_calib_complete,
      output c0_req_valid, c0_req_write, c0_req_addr, c0_req_data, c0_req_mask,
      output c1_req_valid, c1_req_write, c1_req_addr, c1_req_data, c1_req_mask,
      input  c0_req_ready, c1_req_ready,
      input  rsp_valid, rsp_client, rsp_data,
      input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
      output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
      input  rd_outstanding, err_underflow
   );
endinterface

// File: rtl/ddr3_app_arbiter.sv
// Two-client round-robin arbiter/sequencer for the DDR3 controller app interface.
// Grants one single-beat request at a time, drives the command and write-data
// channels, and routes in-order read returns back through a client-tag FIFO.
// Ports:
//   ui_clk          : controller user clock, rising edge
//   ui_clk_sync_rst : synchronous active-high reset
//   bus             : ddr3_app_arbiter_if.master (clients, responses, app_*, status)
module ddr3_app_arbiter #(
   parameter int unsigned ADDR_W = 28,
   parameter int unsigned DATA_W = 256,
   parameter int unsigned MASK_W = DATA_W / 8,
   parameter int unsigned MAX_RD = 16
) (
   input logic                ui_clk,
   input logic                ui_clk_sync_rst,
   ddr3_app_arbiter_if.master bus
);
   localparam int unsigned PTR_W = $clog2(MAX_RD);
   localparam int unsigned CNT_W = $clog2(MAX_RD) + 1;
   localparam logic [2:0]  CMD_WR = 3'b000;
   localparam logic [2:0]  CMD_RD = 3'b001;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic              last_grant;
   logic              cmd_done;
   logic              data_done;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        cmd_q;
   logic [DATA_W-1:0] data_q;
   logic [MASK_W-1:0] mask_q;
   logic [MAX_RD-1:0] tag_mem;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              err_q;

   logic              elig0;
   logic              elig1;
   logic              accept;
   logic              grant_id;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic [MASK_W-1:0] sel_mask;
   logic              cmd_fire;
   logic              data_fire;
   logic              tag_empty;
   logic              push;
   logic              pop;

   // Eligibility and round-robin pick; reads need a free tag slot.
   always_comb begin
      elig0    = bus.c0_req_valid & (bus.c0_req_write | (count < CNT_W'(MAX_RD)));
      elig1    = bus.c1_req_valid & (bus.c1_req_write | (count < CNT_W'(MAX_RD)));
      accept   = (state == IDLE) & bus.init_calib_complete & (elig0 | elig1);
      grant_id = (elig0 & elig1) ? ~last_grant : elig1;
      sel_write = grant_id ? bus.c1_req_write : bus.c0_req_write;
      sel_addr  = grant_id ? bus.c1_req_addr  : bus.c0_req_addr;
      sel_data  = grant_id ? bus.c1_req_data  : bus.c0_req_data;
      sel_mask  = grant_id ? bus.c1_req_mask  : bus.c0_req_mask;
   end

   assign cmd_fire  = (state == ISSUE) & ~cmd_done  & bus.app_rdy;
   assign data_fire = (state == ISSUE) & ~data_done & bus.app_wdf_rdy;

   // State register.
   always_ff @(posedge ui_clk) begin
      if (ui_clk_sync_rst) state <= IDLE;
      else                 state <= state_nxt;
   end

   // Next state: leave ISSUE once both channels are done, counting this cycle's handshakes.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = ISSUE;
         ISSUE:   if ((cmd_done | cmd_fire) & (data_done | data_fire)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: client ready in IDLE, channel enables in ISSUE.
   always_comb begin
      bus.c0_req_ready = 1'b0;
      bus.c1_req_ready = 1'b0;
      bus.app_en       = 1'b0;
      bus.app_wdf_wren = 1'b0;
      bus.app_wdf_end  = 1'b0;
      case (state)
         IDLE: begin
            bus.c0_req_ready = accept & ~grant_id;
            bus.c1_req_ready = accept &  grant_id;
         end
         ISSUE: begin
            bus.app_en       = ~cmd_done;
            bus.app_wdf_wren = ~data_done;
            bus.app_wdf_end  = ~data_done;
         end
         default: ;
      endcase
   end

   // Captured transaction and per-channel completion flags.
   always_ff @(posedge ui_clk) begin
      if (ui_clk_sync_rst) begin
         last_grant <= 1'b1;
         cmd_done   <= 1'b1;
         data_done  <= 1'b1;
         addr_q     <= '0;
         cmd_q      <= CMD_RD;
         data_q     <= '0;
         mask_q     <= '0;
      end else if (accept) begin
         last_grant <= grant_id;
         cmd_done   <= 1'b0;
         data_done  <= ~sel_write;
         addr_q     <= sel_addr;
         cmd_q      <= sel_write ? CMD_WR : CMD_RD;
         data_q     <= sel_data;
         mask_q     <= sel_mask;
      end else begin
         if (cmd_fire)  cmd_done  <= 1'b1;
         if (data_fire) data_done <= 1'b1;
      end
   end

   assign bus.app_addr     = addr_q;
   assign bus.app_cmd      = cmd_q;
   assign bus.app_wdf_data = data_q;
   assign bus.app_wdf_mask = mask_q;

   // Read-tag FIFO; pointers wrap naturally since MAX_RD is a power of two.
   assign tag_empty = (count == '0);
   assign push      = accept & ~sel_write;
   assign pop       = bus.app_rd_data_valid & ~tag_empty;

   always_ff @(posedge ui_clk) begin
      if (ui_clk_sync_rst) begin
         tag_mem <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         err_q   <= 1'b0;
      end else begin
         if (push) begin
            tag_mem[wr_ptr] <= grant_id;
            wr_ptr          <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         if (bus.app_rd_data_valid & tag_empty) err_q <= 1'b1;
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Zero-latency response path.
   assign bus.rsp_valid      = bus.app_rd_data_valid;
   assign bus.rsp_data       = bus.app_rd_data;
   assign bus.rsp_client     = tag_empty ? 1'b0 : tag_mem[rd_ptr];
   assign bus.rd_outstanding = count;
   assign bus.err_underflow  = err_q;
endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Directed testbench for ddr3_app_arbiter (MAX_RD=4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_ddr3_app_arbiter;
   localparam int unsigned ADDR_W = 28;
   localparam int unsigned DATA_W = 256;
   localparam int unsigned MASK_W = DATA_W / 8;
   localparam int unsigned MAX_RD = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   ddr3_app_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .MAX_RD(MAX_RD)) bus ();

   ddr3_app_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .MAX_RD(MAX_RD)) dut (
      .ui_clk          (clk),
      .ui_clk_sync_rst (rst),
      .bus             (bus.master)
   );

   task automatic clear_inputs();
      bus.init_calib_complete = 1'b0;
      bus.c0_req_valid = 1'b0; bus.c0_req_write = 1'b0; bus.c0_req_addr = '0;
      bus.c0_req_data  = '0;   bus.c0_req_mask  = '0;
      bus.c1_req_valid = 1'b0; bus.c1_req_write = 1'b0; bus.c1_req_addr = '0;
      bus.c1_req_data  = '0;   bus.c1_req_mask  = '0;
      bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1;
      bus.app_rd_data = '0; bus.app_rd_data_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      do_reset();
      #1;
      n_checks++; if ({bus.c0_req_ready, bus.c1_req_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {bus.c0_req_ready, bus.c1_req_ready}); end
      n_checks++; if ({bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, bus.rsp_valid} !== 4'b0000) begin n_fail++; $display("FAIL reset_enables: got %b want 0000", {bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, bus.rsp_valid}); end
      n_checks++; if (bus.rd_outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d want 0", bus.rd_outstanding); end
      n_checks++; if (bus.err_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err_underflow); end
      n_checks++; if (bus.app_cmd !== 3'b001) begin n_fail++; $display("FAIL reset_cmd: got %b want 001", bus.app_cmd); end
      n_checks++; if (bus.app_addr !== '0 || bus.app_wdf_data !== '0 || bus.app_wdf_mask !== '0) begin n_fail++; $display("FAIL reset_datapath: addr %h mask %h want zeros", bus.app_addr, bus.app_wdf_mask); end
   endtask

   // Calibration gate, then one read accepted and returned.
   task automatic test_calib();
      logic [DATA_W-1:0] rd = {8{32'hCAFE_0001}};
      do_reset();
      bus.c0_req_valid = 1'b1; bus.c0_req_write = 1'b0; bus.c0_req_addr = 28'h0ABC123;
      #1;
      n_checks++; if (bus.c0_req_ready !== 1'b0 || bus.app_en !== 1'b0) begin n_fail++; $display("FAIL calib_low_0: ready %b en %b want 0 0", bus.c0_req_ready, bus.app_en); end
      @(negedge clk); #1;
      n_checks++; if (bus.c0_req_ready !== 1'b0 || bus.app_en !== 1'b0) begin n_fail++; $display("FAIL calib_low_1: ready %b en %b want 0 0", bus.c0_req_ready, bus.app_en); end
      bus.init_calib_complete = 1'b1;
      #1;
      n_checks++; if (bus.c0_req_ready !== 1'b1) begin n_fail++; $display("FAIL calib_high_ready: got %b want 1", bus.c0_req_ready); end
      @(negedge clk);
      bus.c0_req_valid = 1'b0;
      #1;
      n_checks++; if (bus.app_en !== 1'b1 || bus.app_cmd !== 3'b001 || bus.app_wdf_wren !== 1'b0) begin n_fail++; $display("FAIL calib_issue: en %b cmd %b wren %b want 1 001 0", bus.app_en, bus.app_cmd, bus.app_wdf_wren); end
      n_checks++; if (bus.app_addr !== 28'h0ABC123) begin n_fail++; $display("FAIL calib_addr: got %h want 0abc123", bus.app_addr); end
      n_checks++; if (bus.rd_outstanding !== 3'd1) begin n_fail++; $display("FAIL calib_outstanding: got %0d want 1", bus.rd_outstanding); end
      @(negedge clk); #1;
      n_checks++; if (bus.app_en !== 1'b0) begin n_fail++; $display("FAIL calib_en_drop: got %b want 0", bus.app_en); end
      bus.app_rd_data_valid = 1'b1; bus.app_rd_data = rd;
      #1;
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_client !== 1'b0 || bus.rsp_data !== rd) begin n_fail++; $display("FAIL calib_rsp: valid %b client %b want 1 0", bus.rsp_valid, bus.rsp_client); end
      @(negedge clk);
      bus.app_rd_data_valid = 1'b0;
      #1;
      n_checks++; if (bus.rd_outstanding !== 3'd0) begin n_fail++; $display("FAIL calib_drain: got %0d want 0", bus.rd_outstanding); end
   endtask

   // Both clients writing continuously: grants alternate starting with client 0.
   task automatic test_alternate();
      logic              exp_c;
      logic [ADDR_W-1:0] exp_addr;
      logic [MASK_W-1:0] exp_mask;
      logic [DATA_W-1:0] exp_data;
      do_reset();
      bus.init_calib_complete = 1'b1;
      bus.c0_req_valid = 1'b1; bus.c0_req_write = 1'b1; bus.c0_req_mask = 32'h0000_00F0; bus.c0_req_data = {8{32'h1111_0000}};
      bus.c1_req_valid = 1'b1; bus.c1_req_write = 1'b1; bus.c1_req_mask = 32'h8000_0001; bus.c1_req_data = {8{32'h2222_0000}};
      for (int i = 0; i < 4; i++) begin
         bus.c0_req_addr = 28'h0000100 + ADDR_W'(i);
         bus.c1_req_addr = 28'h0000200 + ADDR_W'(i);
         exp_c    = (i % 2 == 1);
         exp_addr = exp_c ? 28'h0000200 + ADDR_W'(i) : 28'h0000100 + ADDR_W'(i);
         exp_mask = exp_c ? 32'h8000_0001 : 32'h0000_00F0;
         exp_data = exp_c ? {8{32'h2222_0000}} : {8{32'h1111_0000}};
         #1;
         n_checks++; if ({bus.c1_req_ready, bus.c0_req_ready} !== {exp_c, ~exp_c}) begin n_fail++; $display("FAIL alt_grant[%0d]: got c1/c0 %b%b want %b%b", i, bus.c1_req_ready, bus.c0_req_ready, exp_c, ~exp_c); end
         @(negedge clk); #1;
         n_checks++; if ({bus.app_en, bus.app_wdf_wren, bus.app_wdf_end} !== 3'b111 || bus.app_cmd !== 3'b000) begin n_fail++; $display("FAIL alt_issue[%0d]: en/wren/end %b cmd %b want 111 000", i, {bus.app_en, bus.app_wdf_wren, bus.app_wdf_end}, bus.app_cmd); end
         n_checks++; if (bus.app_addr !== exp_addr || bus.app_wdf_mask !== exp_mask || bus.app_wdf_data !== exp_data) begin n_fail++; $display("FAIL alt_payload[%0d]: addr %h mask %h want %h %h", i, bus.app_addr, bus.app_wdf_mask, exp_addr, exp_mask); end
         @(negedge clk);
      end
      bus.c0_req_valid = 1'b0; bus.c1_req_valid = 1'b0;
   endtask

   // Write-data channel stalls: command completes first, wren held until accepted.
   task automatic test_wdf_stall();
      bus.c0_req_valid = 1'b1; bus.c0_req_write = 1'b1; bus.c0_req_addr = 28'h0777777;
      bus.c0_req_data = {8{32'h5A5A_A5A5}}; bus.c0_req_mask = 32'h0F0F_0F0F;
      #1;
      n_checks++; if (bus.c0_req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready: got %b want 1", bus.c0_req_ready); end
      @(negedge clk);
      bus.c0_req_valid = 1'b0; bus.app_wdf_rdy = 1'b0;
      #1;
      n_checks++; if ({bus.app_en, bus.app_wdf_wren} !== 2'b11) begin n_fail++; $display("FAIL stall_c1: en/wren %b want 11", {bus.app_en, bus.app_wdf_wren}); end
      @(negedge clk);
      bus.c1_req_valid = 1'b1; bus.c1_req_write = 1'b1; bus.c1_req_addr = 28'h0123456;
      #1;
      n_checks++; if ({bus.app_en, bus.app_wdf_wren} !== 2'b01) begin n_fail++; $display("FAIL stall_c2: en/wren %b want 01", {bus.app_en, bus.app_wdf_wren}); end
      n_checks++; if (bus.c1_req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_no_grant_in_issue: got %b want 0", bus.c1_req_ready); end
      @(negedge clk); #1;
      n_checks++; if ({bus.app_en, bus.app_wdf_wren} !== 2'b01 || bus.app_wdf_data !== {8{32'h5A5A_A5A5}} || bus.app_wdf_mask !== 32'h0F0F_0F0F) begin n_fail++; $display("FAIL stall_c3: en/wren %b mask %h want 01 0f0f0f0f", {bus.app_en, bus.app_wdf_wren}, bus.app_wdf_mask); end
      @(negedge clk);
      bus.c1_req_valid = 1'b0; bus.app_wdf_rdy = 1'b1;
      #1;
      n_checks++; if ({bus.app_wdf_wren, bus.app_wdf_end} !== 2'b11) begin n_fail++; $display("FAIL stall_c4: wren/end %b want 11", {bus.app_wdf_wren, bus.app_wdf_end}); end
      @(negedge clk); #1;
      n_checks++; if ({bus.app_en, bus.app_wdf_wren} !== 2'b00) begin n_fail++; $display("FAIL stall_done: en/wren %b want 00", {bus.app_en, bus.app_wdf_wren}); end
   endtask

   // Tag FIFO full blocks reads but not writes; one return frees a slot.
   task automatic test_max_rd();
      bus.c1_req_valid = 1'b1; bus.c1_req_write = 1'b0; bus.c1_req_addr = 28'h0300000;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_checks++; if (bus.c1_req_ready !== 1'b1) begin n_fail++; $display("FAIL maxrd_ready[%0d]: got %b want 1", k, bus.c1_req_ready); end
         @(negedge clk); #1;
         n_checks++; if (bus.rd_outstanding !== 3'(k + 1)) begin n_fail++; $display("FAIL maxrd_count[%0d]: got %0d want %0d", k, bus.rd_outstanding, k + 1); end
         @(negedge clk);
      end
      bus.c0_req_valid = 1'b1; bus.c0_req_write = 1'b1; bus.c0_req_addr = 28'h0400000;
      #1;
      n_checks++; if ({bus.c1_req_ready, bus.c0_req_ready} !== 2'b01) begin n_fail++; $display("FAIL maxrd_full_grant: c1/c0 %b want 01", {bus.c1_req_ready, bus.c0_req_ready}); end
      n_checks++; if (bus.rd_outstanding !== 3'd4) begin n_fail++; $display("FAIL maxrd_full_count: got %0d want 4", bus.rd_outstanding); end
      @(negedge clk);
      bus.c0_req_valid = 1'b0;
      #1;
      n_checks++; if (bus.app_en !== 1'b1 || bus.app_cmd !== 3'b000) begin n_fail++; $display("FAIL maxrd_write_issue: en %b cmd %b want 1 000", bus.app_en, bus.app_cmd); end
      @(negedge clk);
      bus.app_rd_data_valid = 1'b1; bus.app_rd_data = {8{32'h0000_0C11}};
      #1;
      n_checks++; if (bus.c1_req_ready !== 1'b0 || bus.rsp_client !== 1'b1) begin n_fail++; $display("FAIL maxrd_blocked: ready %b client %b want 0 1", bus.c1_req_ready, bus.rsp_client); end
      @(negedge clk);
      bus.app_rd_data_valid = 1'b0;
      #1;
      n_checks++; if (bus.rd_outstanding !== 3'd3 || bus.c1_req_ready !== 1'b1) begin n_fail++; $display("FAIL maxrd_freed: count %0d ready %b want 3 1", bus.rd_outstanding, bus.c1_req_ready); end
      @(negedge clk);
      bus.c1_req_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus.app_rd_data_valid = 1'b1;
         #1;
         n_checks++; if (bus.rsp_client !== 1'b1) begin n_fail++; $display("FAIL maxrd_drain[%0d]: client %b want 1", k, bus.rsp_client); end
      end
      @(negedge clk);
      bus.app_rd_data_valid = 1'b0;
      #1;
      n_checks++; if (bus.rd_outstanding !== 3'd0) begin n_fail++; $display("FAIL maxrd_empty: got %0d want 0", bus.rd_outstanding); end
   endtask

   // Reads from c0,c1,c1,c0 come back tagged in order; push+pop keeps the count.
   task automatic test_interleave();
      logic [3:0]        order = 4'b0110;
      logic [DATA_W-1:0] rdat;
      logic              exp_c;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.c0_req_valid = ~order[i]; bus.c0_req_write = 1'b0; bus.c0_req_addr = 28'h0500000 + ADDR_W'(i);
         bus.c1_req_valid =  order[i]; bus.c1_req_write = 1'b0; bus.c1_req_addr = 28'h0600000 + ADDR_W'(i);
         if (i == 3) begin
            bus.app_rd_data_valid = 1'b1; bus.app_rd_data = {8{32'hD000_0000}};
         end
         #1;
         n_checks++; if ({bus.c1_req_ready, bus.c0_req_ready} !== {order[i], ~order[i]}) begin n_fail++; $display("FAIL ilv_grant[%0d]: c1/c0 %b%b want %b%b", i, bus.c1_req_ready, bus.c0_req_ready, order[i], ~order[i]); end
         if (i == 3) begin
            n_checks++; if (bus.rsp_client !== 1'b0 || bus.rsp_data !== {8{32'hD000_0000}}) begin n_fail++; $display("FAIL ilv_rsp0: client %b want 0", bus.rsp_client); end
         end
         @(negedge clk);
         bus.c0_req_valid = 1'b0; bus.c1_req_valid = 1'b0; bus.app_rd_data_valid = 1'b0;
      end
      #1;
      n_checks++; if (bus.rd_outstanding !== 3'd3) begin n_fail++; $display("FAIL ilv_push_pop_count: got %0d want 3", bus.rd_outstanding); end
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         rdat  = {8{32'hD000_0000 + 32'(k)}};
         exp_c = order[k];
         bus.app_rd_data_valid = 1'b1; bus.app_rd_data = rdat;
         #1;
         n_checks++; if (bus.rsp_client !== exp_c || bus.rsp_data !== rdat) begin n_fail++; $display("FAIL ilv_rsp[%0d]: client %b want %b", k, bus.rsp_client, exp_c); end
      end
      @(negedge clk);
      bus.app_rd_data_valid = 1'b0;
      #1;
      n_checks++; if (bus.rd_outstanding !== 3'd0 || bus.err_underflow !== 1'b0) begin n_fail++; $display("FAIL ilv_end: count %0d err %b want 0 0", bus.rd_outstanding, bus.err_underflow); end
   endtask

   // Read data with nothing outstanding sets a sticky error cleared only by reset.
   task automatic test_underflow();
      @(negedge clk);
      bus.app_rd_data_valid = 1'b1; bus.app_rd_data = {8{32'hBAD0_BAD0}};
      #1;
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_client !== 1'b0) begin n_fail++; $display("FAIL uf_rsp: valid %b client %b want 1 0", bus.rsp_valid, bus.rsp_client); end
      @(negedge clk);
      bus.app_rd_data_valid = 1'b0;
      #1;
      n_checks++; if (bus.err_underflow !== 1'b1 || bus.rd_outstanding !== 3'd0) begin n_fail++; $display("FAIL uf_set: err %b count %0d want 1 0", bus.err_underflow, bus.rd_outstanding); end
      repeat (3) @(negedge clk);
      #1;
      n_checks++; if (bus.err_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b want 1", bus.err_underflow); end
      do_reset();
      #1;
      n_checks++; if (bus.err_underflow !== 1'b0) begin n_fail++; $display("FAIL uf_reset: got %b want 0", bus.err_underflow); end
   endtask

   initial begin
      test_reset();
      test_calib();
      test_alternate();
      test_wdf_stall();
      test_max_rd();
      test_interleave();
      test_underflow();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
